// File: rtl/aes128_decrypt_iter_if.sv
// Purpose : valid/ready bus bundle for the iterative AES-128 decryptor.
// Signals : in_valid/in_ready/ciphertext/cipher_key  - ciphertext/key input channel
//           out_valid/out_ready/plaintext            - plaintext output channel
// Modports: master drives the input channel and out_ready; slave is the decryptor side.
interface aes128_decrypt_iter_if;
    localparam int unsigned BLK_W = 128;

    logic             in_valid;
    logic             in_ready;
    logic [BLK_W-1:0] ciphertext;
    logic [BLK_W-1:0] cipher_key;
    logic             out_valid;
    logic             out_ready;
    logic [BLK_W-1:0] plaintext;

    modport master (
        output in_valid, ciphertext, cipher_key, out_ready,
        input  in_ready, out_valid, plaintext
    );

    modport slave (
        input  in_valid, ciphertext, cipher_key, out_ready,
        output in_ready, out_valid, plaintext
    );
endinterface

// File: rtl/aes128_decrypt_iter.sv
// Purpose : iterative AES-128 inverse cipher, one round per clock, 13 cycles per block
//           with the output drained immediately.
// Ports   : clk, rst (async, active-high)
//           bus       - aes128_decrypt_iter_if.slave (ciphertext/key in, plaintext out)
//           busy      - high whenever the FSM is not in IDLE
//           blk_count - completed-block counter, present only when AES_DEC_STATUS_EN is defined
// Config  : `define AES_DEC_STATUS_EN adds parameter CNT_W and the blk_count port/counter.
module aes128_decrypt_iter
`ifdef AES_DEC_STATUS_EN
#(
    parameter int unsigned CNT_W = 16
)
`endif
(
    input  logic                      clk,
    input  logic                      rst,
    aes128_decrypt_iter_if.slave      bus,
    output logic                      busy
`ifdef AES_DEC_STATUS_EN
    ,
    output logic [CNT_W-1:0]          blk_count
`endif
);

    localparam int unsigned BLK_W = 128;
    localparam int unsigned RK_W  = 1408;
    localparam int unsigned RND_W = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ROUND = 3'd2,
        FINAL = 3'd3,
        DONE  = 3'd4
    } state_t;

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0)
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] sq;
        r  = 8'h01;
        sq = x;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int unsigned n);
        logic [15:0] d;
        d = {b, b};
        return d[15-n -: 8];
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] b;
        b = gf_inv(x);
        return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    endfunction

    // Undo the affine map first, then invert in the field
    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        return gf_inv(rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05);
    endfunction

    // Byte k of a block sits at bits [127-8k -: 8]; byte k is row k%4, column k/4
    function automatic logic [BLK_W-1:0] inv_shift_sub(input logic [BLK_W-1:0] s);
        logic [BLK_W-1:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(r+4*c) -: 8] = inv_sbox(s[127-8*(r+4*((c-r+4)%4)) -: 8]);
            end
        end
        return o;
    endfunction

    function automatic logic [BLK_W-1:0] inv_mix_columns(input logic [BLK_W-1:0] s);
        logic [BLK_W-1:0] o;
        logic [7:0]       a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gf_mul(a0, 8'd14) ^ gf_mul(a1, 8'd11) ^ gf_mul(a2, 8'd13) ^ gf_mul(a3, 8'd9);
            o[119-32*c -: 8] = gf_mul(a0, 8'd9)  ^ gf_mul(a1, 8'd14) ^ gf_mul(a2, 8'd11) ^ gf_mul(a3, 8'd13);
            o[111-32*c -: 8] = gf_mul(a0, 8'd13) ^ gf_mul(a1, 8'd9)  ^ gf_mul(a2, 8'd14) ^ gf_mul(a3, 8'd11);
            o[103-32*c -: 8] = gf_mul(a0, 8'd11) ^ gf_mul(a1, 8'd13) ^ gf_mul(a2, 8'd9)  ^ gf_mul(a3, 8'd14);
        end
        return o;
    endfunction

    // Full AES-128 key schedule: 44 words, word 0 in the top bits
    function automatic logic [RK_W-1:0] key_gen(input logic [BLK_W-1:0] key);
        logic [31:0]     w [44];
        logic [31:0]     t;
        logic [7:0]      rc;
        logic [RK_W-1:0] rk;
        rk = '0;
        rc = 8'h01;
        for (int i = 0; i < 44; i++) begin
            if (i < 4) begin
                w[i] = key[127-32*i -: 32];
            end else begin
                t = w[i-1];
                if (i % 4 == 0) begin
                    t  = {sbox(t[23:16]) ^ rc, sbox(t[15:8]), sbox(t[7:0]), sbox(t[31:24])};
                    rc = gf_mul(rc, 8'h02);
                end
                w[i] = w[i-4] ^ t;
            end
            rk[RK_W-1-32*i -: 32] = w[i];
        end
        return rk;
    endfunction

    state_t             state, state_d;
    logic [BLK_W-1:0]   st_q, st_d;
    logic [BLK_W-1:0]   key_q, key_d;
    logic [RND_W-1:0]   rnd, rnd_d;
    logic [BLK_W-1:0]   pt_q, pt_d;
    logic               out_valid_q, out_valid_d;
    logic               in_ready_q, in_ready_d;
    logic               busy_q, busy_d;
    logic [RK_W-1:0]    round_keys;
    logic [BLK_W-1:0]   rk_sel;

    // Round keys follow the latched key
    always_comb begin : keygen
        round_keys = key_gen(key_q);
    end

    // Round key for the current round counter
    always_comb begin
        rk_sel = '0;
        for (int i = 0; i < 11; i++) begin
            if (rnd == RND_W'(i)) rk_sel = round_keys[RK_W-1-128*i -: 128];
        end
    end

    // Next-state and datapath
    always_comb begin
        state_d     = state;
        st_d        = st_q;
        key_d       = key_q;
        rnd_d       = rnd;
        pt_d        = pt_q;
        out_valid_d = out_valid_q;
        case (state)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    st_d    = bus.ciphertext;
                    key_d   = bus.cipher_key;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                st_d    = st_q ^ round_keys[127:0];
                rnd_d   = RND_W'(9);
                state_d = ROUND;
            end
            ROUND: begin
                st_d = inv_mix_columns(inv_shift_sub(st_q) ^ rk_sel);
                if (rnd != '0) rnd_d = rnd - RND_W'(1);
                if (rnd <= RND_W'(1)) state_d = FINAL;
            end
            FINAL: begin
                pt_d        = inv_shift_sub(st_q) ^ round_keys[RK_W-1 -: 128];
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (out_valid_q && bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
        in_ready_d = (state_d == IDLE);
        busy_d     = (state_d != IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            st_q        <= '0;
            key_q       <= '0;
            rnd         <= '0;
            pt_q        <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state       <= state_d;
            st_q        <= st_d;
            key_q       <= key_d;
            rnd         <= rnd_d;
            pt_q        <= pt_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

`ifdef AES_DEC_STATUS_EN
    // Completed blocks, counted on each output handshake; wraps naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blk_count <= '0;
        end else if (out_valid_q && bus.out_ready) begin
            blk_count <= blk_count + CNT_W'(1);
        end
    end
`endif

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.plaintext = pt_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_aes128_decrypt_iter.sv
// Purpose : self-checking bench for aes128_decrypt_iter. Expected plaintexts come from
//           FIPS-197 vectors and from a forward AES-128 encryption model: random
//           plaintext/key pairs are encrypted here and the DUT must recover them.
// Ports   : none; instantiates the interface and the DUT, 100 MHz clock.
module tb_aes128_decrypt_iter;

    logic clk = 1'b0;
    logic rst;
    logic busy;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    aes128_decrypt_iter_if bus ();

`ifdef AES_DEC_STATUS_EN
    localparam int CNT_W = 2;
    logic [CNT_W-1:0] blk_count;
    aes128_decrypt_iter #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .busy      (busy),
        .blk_count (blk_count)
    );
`else
    aes128_decrypt_iter dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] P1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] C2  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] P2  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C0  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    // ---------------- reference model: forward AES-128 ----------------
    logic [7:0] sbox_t [256];

    function automatic logic [7:0] rol8(input logic [7:0] x, input int n);
        return 8'((x << n) | (x >> (8 - n)));
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return 8'(x << 1) ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // S-box from walking the multiplicative group with generator 3
    task automatic init_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ xtime(p);
            q = q ^ 8'(q << 1);
            q = q ^ 8'(q << 2);
            q = q ^ 8'(q << 4);
            if (q[7]) q = q ^ 8'h09;
            x = q ^ rol8(q, 1) ^ rol8(q, 2) ^ rol8(q, 3) ^ rol8(q, 4);
            sbox_t[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbox_t[0] = 8'h63;
    endtask

    function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] key);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   rk [176];
        logic [7:0]   tm [4];
        logic [7:0]   rc;
        logic [7:0]   a0, a1, a2, a3, sw;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) begin
            rk[i] = key[127-8*i -: 8];
            s[i]  = pt[127-8*i -: 8];
        end
        rc = 8'h01;
        for (int i = 16; i < 176; i += 4) begin
            for (int j = 0; j < 4; j++) tm[j] = rk[i-4+j];
            if (i % 16 == 0) begin
                sw    = tm[0];
                tm[0] = sbox_t[tm[1]] ^ rc;
                tm[1] = sbox_t[tm[2]];
                tm[2] = sbox_t[tm[3]];
                tm[3] = sbox_t[sw];
                rc    = xtime(rc);
            end
            for (int j = 0; j < 4; j++) rk[i+j] = rk[i-16+j] ^ tm[j];
        end
        for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[i];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) s[i] = sbox_t[s[i]];
            for (int c = 0; c < 4; c++)
                for (int w = 0; w < 4; w++) t[w+4*c] = s[w+4*((c+w)%4)];
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                if (r < 10) begin
                    s[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
                    s[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
                end else begin
                    s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[16*r+i];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- stimulus helpers (no checking inside) ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        bus.in_valid   = 1'b0;
        bus.out_ready  = 1'b0;
        bus.ciphertext = '0;
        bus.cipher_key = '0;
        repeat (2) tick();
        rst = 1'b0;
        tick();
    endtask

    // Waits for in_ready, presents one pair for one edge; returns the accept cycle.
    task automatic start_block(input logic [127:0] ct, input logic [127:0] key, output int acc);
        int n;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            tick();
            n++;
        end
        bus.ciphertext = ct;
        bus.cipher_key = key;
        bus.in_valid   = 1'b1;
        tick();
        acc            = cyc;
        bus.in_valid   = 1'b0;
        bus.ciphertext = rand128();
        bus.cipher_key = rand128();
    endtask

    // Counts edges until out_valid; 40 means it never came.
    task automatic wait_out(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic drain();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: in_ready=%b out_valid=%b busy=%b required 1 0 0",
                     bus.in_ready, bus.out_valid, busy);
        end
        checks++;
        if (bus.plaintext !== 128'h0) begin
            errors++;
            $display("FAIL reset_pt: got %h required 0", bus.plaintext);
        end
    endtask

    task automatic test_fips_c1();
        int acc, lat;
        start_block(C1, K1, acc);
        checks++;
        if (busy !== 1'b1 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL c1_busy: busy=%b in_ready=%b required 1 0", busy, bus.in_ready);
        end
        wait_out(lat);
        checks++;
        if (lat !== 11) begin
            errors++;
            $display("FAIL c1_latency: got %0d required 11", lat);
        end
        checks++;
        if (bus.plaintext !== P1) begin
            errors++;
            $display("FAIL c1_pt: got %h required %h", bus.plaintext, P1);
        end
        drain();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL c1_drain: out_valid=%b in_ready=%b busy=%b required 0 1 0",
                     bus.out_valid, bus.in_ready, busy);
        end
    endtask

    task automatic test_fips_b();
        int acc, lat;
        start_block(C2, K2, acc);
        wait_out(lat);
        checks++;
        if (lat !== 11) begin
            errors++;
            $display("FAIL b_latency: got %0d required 11", lat);
        end
        checks++;
        if (bus.plaintext !== P2) begin
            errors++;
            $display("FAIL b_pt: got %h required %h", bus.plaintext, P2);
        end
        drain();
    endtask

    task automatic test_backpressure();
        int acc, lat;
        start_block(C0, 128'h0, acc);
        wait_out(lat);
        checks++;
        if (lat !== 11 || bus.plaintext !== 128'h0) begin
            errors++;
            $display("FAIL bp_first: lat=%0d pt=%h required 11 and 0", lat, bus.plaintext);
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (bus.plaintext !== 128'h0 || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold cycle %0d: pt=%h out_valid=%b in_ready=%b required 0 1 0",
                         i, bus.plaintext, bus.out_valid, bus.in_ready);
            end
        end
        drain();
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: in_ready=%b out_valid=%b required 1 0",
                     bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_ignore_while_busy();
        int acc, lat;
        start_block(C1, K1, acc);
        repeat (3) tick();
        bus.ciphertext = C2;
        bus.cipher_key = K2;
        bus.in_valid   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (bus.in_ready !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL ign_ready: in_ready=%b busy=%b required 0 1", bus.in_ready, busy);
            end
        end
        bus.in_valid = 1'b0;
        wait_out(lat);
        checks++;
        if (lat + 7 !== 11) begin
            errors++;
            $display("FAIL ign_latency: got %0d required 11", lat + 7);
        end
        checks++;
        if (bus.plaintext !== P1) begin
            errors++;
            $display("FAIL ign_pt: got %h required %h", bus.plaintext, P1);
        end
        drain();
        repeat (2) tick();
        checks++;
        if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ign_no_second: out_valid=%b busy=%b required 0 0", bus.out_valid, busy);
        end
    endtask

    task automatic test_reset_midblock();
        int acc, lat;
        start_block(C1, K1, acc);
        repeat (5) tick();
        rst = 1'b1;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid: out_valid=%b busy=%b in_ready=%b required 0 0 1",
                     bus.out_valid, busy, bus.in_ready);
        end
        tick();
        rst = 1'b0;
        tick();
        start_block(C2, K2, acc);
        wait_out(lat);
        checks++;
        if (lat !== 11 || bus.plaintext !== P2) begin
            errors++;
            $display("FAIL rst_rerun: lat=%0d pt=%h required 11 and %h", lat, bus.plaintext, P2);
        end
        drain();
    endtask

    task automatic test_random();
        logic [127:0] pt, key, ct;
        int acc, lat;
        for (int k = 0; k < 20; k++) begin
            pt  = rand128();
            key = rand128();
            ct  = aes_enc(pt, key);
            repeat ($urandom_range(0, 2)) tick();
            start_block(ct, key, acc);
            wait_out(lat);
            checks++;
            if (lat !== 11 || bus.plaintext !== pt) begin
                errors++;
                $display("FAIL rand_%0d: lat=%0d pt=%h required 11 and %h", k, lat, bus.plaintext, pt);
            end
            repeat ($urandom_range(0, 3)) tick();
            drain();
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] pt, key;
        int acc, prev_acc, lat;
        int exp_cnt;
        do_reset();
        exp_cnt       = 0;
        prev_acc      = 0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            pt  = rand128();
            key = rand128();
            start_block(aes_enc(pt, key), key, acc);
            if (k > 0) begin
                checks++;
                if (acc - prev_acc !== 13) begin
                    errors++;
                    $display("FAIL b2b_spacing_%0d: got %0d required 13", k, acc - prev_acc);
                end
            end
            prev_acc = acc;
            wait_out(lat);
            checks++;
            if (lat !== 11 || bus.plaintext !== pt) begin
                errors++;
                $display("FAIL b2b_%0d: lat=%0d pt=%h required 11 and %h", k, lat, bus.plaintext, pt);
            end
            tick();
            exp_cnt = (exp_cnt + 1) % 4;
`ifdef AES_DEC_STATUS_EN
            checks++;
            if (int'(blk_count) !== exp_cnt) begin
                errors++;
                $display("FAIL blk_count_%0d: got %0d required %0d", k, blk_count, exp_cnt);
            end
`endif
        end
        bus.out_ready = 1'b0;
    endtask

    initial begin
        init_sbox();
        rst            = 1'b1;
        bus.in_valid   = 1'b0;
        bus.out_ready  = 1'b0;
        bus.ciphertext = '0;
        bus.cipher_key = '0;
        test_reset();
        test_fips_c1();
        test_fips_b();
        test_backpressure();
        test_ignore_while_busy();
        test_reset_midblock();
        test_random();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within 500000 ns");
        $fatal(1, "watchdog");
    end

endmodule
